// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute controller that owns the instruction address.
//               It handshakes with instruction memory (imem_req/imem_ack) and
//               the datapath (exec_done), then selects the next address:
//               sequential, relative branch or halt. A stalled fetch raises a
//               sticky timeout error.
//               Optional macro PC_SEQ_RET_STACK_EN adds call/return support
//               backed by a 4-entry circular return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int ADDR_W        = 4,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [7:0]        branch_offset,
  input  logic              halt_req,
`ifdef PC_SEQ_RET_STACK_EN
  input  logic              is_call,
  input  logic              is_ret,
  output logic              stack_err,
`endif
  output logic [ADDR_W-1:0] instruction_addr,
  output logic [2:0]        state,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_one          = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        c_timeout_last = 8'(FETCH_TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_instr_valid;
  logic              r_timeout_err;
  logic [7:0]        r_fetch_cnt;

  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [ADDR_W-1:0] w_branch_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_exec_fire;
  logic              w_unused_offset_bits;

  // Only the low ADDR_W bits of the offset take part in address arithmetic.
  assign w_offset             = branch_offset[ADDR_W-1:0];
  assign w_unused_offset_bits = &{1'b0, branch_offset[7:ADDR_W]};

  // A zero offset would loop on the same instruction forever, so it steps by one.
  assign w_seq_addr    = r_addr + c_one;
  assign w_branch_addr = (w_offset == '0) ? w_seq_addr : r_addr + w_offset;
  assign w_exec_fire   = (r_state == S_EXEC) && exec_done;

`ifdef PC_SEQ_RET_STACK_EN
  logic [ADDR_W-1:0] r_stack [4];
  logic [1:0]        r_wp;
  logic [2:0]        r_depth;
  logic              r_stack_err;
  logic [1:0]        w_top_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_pop_empty;

  assign w_top_idx   = r_wp - 2'd1;
  assign w_pop       = w_exec_fire && !halt_req && is_ret;
  assign w_push      = w_exec_fire && !halt_req && !is_ret && is_call;
  assign w_pop_empty = (r_depth == 3'd0);
  assign stack_err   = r_stack_err;

  // Next address with return-stack priority: ret > call > branch > sequential.
  always_comb begin
    w_next_addr = w_seq_addr;
    if (is_ret) begin
      w_next_addr = w_pop_empty ? w_seq_addr : r_stack[w_top_idx];
    end else if (is_call || branch_taken) begin
      w_next_addr = w_branch_addr;
    end
  end

  // Circular return-address stack: a full push overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_stack[i] <= '0;
      r_wp        <= 2'd0;
      r_depth     <= 3'd0;
      r_stack_err <= 1'b0;
    end else if (w_push) begin
      r_stack[r_wp] <= w_seq_addr;
      r_wp          <= r_wp + 2'd1;
      if (r_depth != 3'd4) r_depth <= r_depth + 3'd1;
    end else if (w_pop) begin
      if (w_pop_empty) begin
        r_stack_err <= 1'b1;
      end else begin
        r_wp    <= w_top_idx;
        r_depth <= r_depth - 3'd1;
      end
    end
  end
`else
  // Next address: branch target when taken, otherwise the following word.
  always_comb begin
    w_next_addr = branch_taken ? w_branch_addr : w_seq_addr;
  end
`endif

  // Main fetch/execute state machine with registered address and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_instr_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_fetch_cnt   <= 8'd0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          r_fetch_cnt <= 8'd0;
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // An ack in the limit cycle still counts as a successful fetch.
          if (imem_ack) begin
            r_state       <= S_EXEC;
            r_instr_valid <= 1'b1;
            r_fetch_cnt   <= 8'd0;
          end else if (r_fetch_cnt == c_timeout_last) begin
            r_state       <= S_ERR;
            r_timeout_err <= 1'b1;
            r_fetch_cnt   <= 8'd0;
          end else begin
            r_fetch_cnt <= r_fetch_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          r_fetch_cnt <= 8'd0;
          if (exec_done) begin
            if (halt_req) begin
              r_state <= S_HALT;
            end else begin
              r_addr  <= w_next_addr;
              r_state <= S_FETCH;
            end
          end
        end
        S_ERR: begin
          r_fetch_cnt <= 8'd0;
        end
        default: begin
          r_state     <= S_ERR;
          r_fetch_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign imem_req         = (r_state == S_FETCH);
  assign instr_valid      = r_instr_valid;
  assign instruction_addr = r_addr;
  assign state            = r_state;
  assign timeout_err      = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_fetch = 3'd1;
  localparam logic [2:0] c_exec  = 3'd2;
  localparam logic [2:0] c_halt  = 3'd3;
  localparam logic [2:0] c_err   = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       imem_req;
  logic       imem_ack;
  logic       instr_valid;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       halt_req;
  logic [3:0] instruction_addr;
  logic [2:0] state;
  logic       timeout_err;
`ifdef PC_SEQ_RET_STACK_EN
  logic       is_call;
  logic       is_ret;
  logic       stack_err;
`endif

  int checks;
  int errors;

  pc_sequencer #(
    .ADDR_W       (4),
    .FETCH_TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .instr_valid     (instr_valid),
    .exec_done       (exec_done),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .halt_req        (halt_req),
`ifdef PC_SEQ_RET_STACK_EN
    .is_call         (is_call),
    .is_ret          (is_ret),
    .stack_err       (stack_err),
`endif
    .instruction_addr(instruction_addr),
    .state           (state),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clear all inputs and hold reset across an edge, leaving the bench at posedge+1.
  task automatic reset_dut();
    start = 0; imem_ack = 0; exec_done = 0; branch_taken = 0;
    branch_offset = 8'h00; halt_req = 0;
`ifdef PC_SEQ_RET_STACK_EN
    is_call = 0; is_ret = 0;
`endif
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Reset, then run n immediate sequential instructions; ends in EXEC at address n.
  task automatic goto_exec(input int n);
    reset_dut();
    start = 1;
    @(posedge clk); #1;
    start = 0; imem_ack = 1; exec_done = 1;
    repeat (2 * n) @(posedge clk);
    #1;
    exec_done = 0;
    @(posedge clk); #1;
    imem_ack = 0;
  endtask

  task automatic test_reset();
    start = 0; imem_ack = 0; exec_done = 0; branch_taken = 0;
    branch_offset = 8'h00; halt_req = 0;
`ifdef PC_SEQ_RET_STACK_EN
    is_call = 0; is_ret = 0;
`endif
    rst_n = 0;
    #2;
    checks++; if (state !== c_idle) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, c_idle); end
    checks++; if (instruction_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", instruction_addr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequential();
    reset_dut();
    start = 1; imem_ack = 1; exec_done = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 17; i++) begin
      checks++; if (state !== c_fetch || imem_req !== 1'b1 || instr_valid !== 1'b0)
        begin errors++; $display("FAIL seq_fetch[%0d] got st=%0d req=%b v=%b exp st=1 req=1 v=0", i, state, imem_req, instr_valid); end
      checks++; if (instruction_addr !== 4'(i))
        begin errors++; $display("FAIL seq_addr[%0d] got %0d exp %0d", i, instruction_addr, i % 16); end
      @(posedge clk); #1;
      checks++; if (state !== c_exec || instr_valid !== 1'b1 || instruction_addr !== 4'(i))
        begin errors++; $display("FAIL seq_exec[%0d] got st=%0d v=%b a=%0d exp st=2 v=1 a=%0d", i, state, instr_valid, instruction_addr, i % 16); end
      if (i == 16) begin exec_done = 0; imem_ack = 0; end
      @(posedge clk); #1;
    end
    checks++; if (state !== c_exec || instr_valid !== 1'b0 || instruction_addr !== 4'd0)
      begin errors++; $display("FAIL seq_end got st=%0d v=%b a=%0d exp st=2 v=0 a=0", state, instr_valid, instruction_addr); end
  endtask

  task automatic test_branch();
    goto_exec(14);
    branch_taken = 1; branch_offset = 8'h03; exec_done = 1;
    @(posedge clk); #1;
    exec_done = 0; branch_taken = 0;
    checks++; if (instruction_addr !== 4'd1 || state !== c_fetch)
      begin errors++; $display("FAIL branch_wrap got a=%0d st=%0d exp a=1 st=1", instruction_addr, state); end
    goto_exec(5);
    branch_taken = 1; branch_offset = 8'hF0; exec_done = 1;
    @(posedge clk); #1;
    exec_done = 0; branch_taken = 0;
    checks++; if (instruction_addr !== 4'd6 || state !== c_fetch)
      begin errors++; $display("FAIL branch_zero got a=%0d st=%0d exp a=6 st=1", instruction_addr, state); end
    goto_exec(3);
    branch_taken = 1; branch_offset = 8'h2D; exec_done = 1;
    @(posedge clk); #1;
    exec_done = 0; branch_taken = 0;
    checks++; if (instruction_addr !== 4'd0)
      begin errors++; $display("FAIL branch_back got a=%0d exp a=0", instruction_addr); end
  endtask

  task automatic test_timeout();
    reset_dut();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (state !== c_fetch || timeout_err !== 1'b0)
      begin errors++; $display("FAIL tmo_before got st=%0d terr=%b exp st=1 terr=0", state, timeout_err); end
    @(posedge clk); #1;
    checks++; if (state !== c_err || timeout_err !== 1'b1 || imem_req !== 1'b0)
      begin errors++; $display("FAIL tmo_err got st=%0d terr=%b req=%b exp st=4 terr=1 req=0", state, timeout_err, imem_req); end
    start = 1; imem_ack = 1; exec_done = 1;
    repeat (3) @(posedge clk);
    #1;
    start = 0; imem_ack = 0; exec_done = 0;
    checks++; if (state !== c_err || timeout_err !== 1'b1)
      begin errors++; $display("FAIL tmo_sticky got st=%0d terr=%b exp st=4 terr=1", state, timeout_err); end
    rst_n = 0;
    #1;
    checks++; if (state !== c_idle || timeout_err !== 1'b0 || instruction_addr !== 4'd0)
      begin errors++; $display("FAIL tmo_reset got st=%0d terr=%b a=%0d exp st=0 terr=0 a=0", state, timeout_err, instruction_addr); end
    rst_n = 1;
    // Ack arriving in the limit cycle still wins.
    reset_dut();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (7) @(posedge clk);
    #1;
    imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0;
    checks++; if (state !== c_exec || timeout_err !== 1'b0 || instr_valid !== 1'b1)
      begin errors++; $display("FAIL tmo_ack_wins got st=%0d terr=%b v=%b exp st=2 terr=0 v=1", state, timeout_err, instr_valid); end
  endtask

  task automatic test_halt();
    goto_exec(7);
    halt_req = 1; branch_taken = 1; branch_offset = 8'h03; exec_done = 1;
    @(posedge clk); #1;
    halt_req = 0; branch_taken = 0;
    checks++; if (state !== c_halt || instruction_addr !== 4'd7 || imem_req !== 1'b0)
      begin errors++; $display("FAIL halt_enter got st=%0d a=%0d req=%b exp st=3 a=7 req=0", state, instruction_addr, imem_req); end
    imem_ack = 1;
    @(posedge clk); #1;
    exec_done = 0; imem_ack = 0;
    checks++; if (state !== c_halt || instruction_addr !== 4'd7)
      begin errors++; $display("FAIL halt_hold got st=%0d a=%0d exp st=3 a=7", state, instruction_addr); end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++; if (state !== c_fetch || imem_req !== 1'b1 || instruction_addr !== 4'd7)
      begin errors++; $display("FAIL halt_resume got st=%0d req=%b a=%0d exp st=1 req=1 a=7", state, imem_req, instruction_addr); end
  endtask

  task automatic test_async_reset();
    goto_exec(9);
    checks++; if (state !== c_exec || instruction_addr !== 4'd9 || instr_valid !== 1'b1)
      begin errors++; $display("FAIL arst_pre got st=%0d a=%0d v=%b exp st=2 a=9 v=1", state, instruction_addr, instr_valid); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (state !== c_idle || instruction_addr !== 4'd0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL arst_now got st=%0d a=%0d v=%b exp st=0 a=0 v=0", state, instruction_addr, instr_valid); end
    #1;
    rst_n = 1;
    exec_done = 1; branch_taken = 1; branch_offset = 8'h05; imem_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    exec_done = 0; branch_taken = 0; imem_ack = 0;
    checks++; if (state !== c_idle || instruction_addr !== 4'd0)
      begin errors++; $display("FAIL idle_stray got st=%0d a=%0d exp st=0 a=0", state, instruction_addr); end
  endtask

`ifdef PC_SEQ_RET_STACK_EN
  task automatic test_ret_stack();
    goto_exec(2);
    is_call = 1; branch_offset = 8'h04; exec_done = 1;
    @(posedge clk); #1;
    is_call = 0; exec_done = 0;
    checks++; if (instruction_addr !== 4'd6)
      begin errors++; $display("FAIL call_addr got %0d exp 6", instruction_addr); end
    imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0; is_ret = 1; exec_done = 1;
    @(posedge clk); #1;
    is_ret = 0; exec_done = 0;
    checks++; if (instruction_addr !== 4'd3 || stack_err !== 1'b0)
      begin errors++; $display("FAIL ret_addr got a=%0d serr=%b exp a=3 serr=0", instruction_addr, stack_err); end
    imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0; is_ret = 1; exec_done = 1;
    @(posedge clk); #1;
    is_ret = 0; exec_done = 0;
    checks++; if (instruction_addr !== 4'd4 || stack_err !== 1'b1)
      begin errors++; $display("FAIL ret_empty got a=%0d serr=%b exp a=4 serr=1", instruction_addr, stack_err); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_timeout();
    test_halt();
    test_async_reset();
`ifdef PC_SEQ_RET_STACK_EN
    test_ret_stack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute controller that owns and sequences the 4-bit instruction address of the CPU.
- Handshakes with instruction memory (req/ack) and with the execute datapath (exec_done), then computes the next address: sequential, relative branch, or halt.
- Sits between the instruction ROM and the datapath control. Supersedes free-running program counter increment with stall-aware sequencing.

Parameters:
- ADDR_W, 4, instruction address width; arithmetic is modulo 2^ADDR_W.
- FETCH_TIMEOUT, 8, maximum cycles in FETCH without imem_ack before the error state (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE or HALT and begin fetching.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction memory has returned the instruction.
- instr_valid  out  1  one-cycle pulse: the instruction at instruction_addr is captured.
- exec_done  in  1  datapath finished the current instruction.
- branch_taken  in  1  sampled with exec_done; select relative jump.
- branch_offset  in  8  jump distance; only [ADDR_W-1:0] is used.
- halt_req  in  1  sampled with exec_done; stop after this instruction.
- instruction_addr  out  ADDR_W  current instruction address (registered).
- state  out  3  FSM state encoding.
- timeout_err  out  1  sticky fetch timeout flag.
- is_call, is_ret  in  1 each  present only with RET_STACK_EN.
- stack_err  out  1  present only with RET_STACK_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, instruction_addr=0, instr_valid=0, timeout_err=0, timeout counter=0; imem_req=0 follows from the state. Reset mid-fetch or mid-exec aborts immediately. No pending request survives reset.
- State encoding: IDLE=0, FETCH=1, EXEC=2, HALT=3, ERR=4.
- imem_req is decoded from state: 1 exactly while state==FETCH.
- IDLE: start=1 -> FETCH on the next edge. All other inputs are ignored.
- FETCH: the timeout counter increments each cycle without ack.
  - imem_ack=1 -> EXEC; instr_valid=1 for exactly the following cycle; counter cleared.
  - Counter reaching FETCH_TIMEOUT without ack -> ERR; timeout_err=1.
  - Ack arriving in the same cycle as the counter limit wins: go to EXEC.
- EXEC: wait for exec_done. On exec_done=1, priority is halt_req > branch_taken > sequential.
  - halt_req=1 -> HALT; instruction_addr is unchanged, so execution resumes at the same address.
  - branch_taken=1 -> addr += offset[ADDR_W-1:0]; an offset field of 0 is treated as +1 (no self-loop). Then FETCH.
  - Otherwise -> addr += 1, then FETCH.
  - All additions wrap modulo 16 (e.g. 15+1=0, 14+3=1).
- HALT: start=1 -> FETCH at the held address. exec_done and imem_ack are ignored.
- ERR: absorbing state; only rst_n exits. timeout_err stays 1.
- Inputs ignored outside their sampling state: exec_done, branch_taken and halt_req outside EXEC; imem_ack outside FETCH; start outside IDLE/HALT.
- Minimum instruction period is 2 cycles (ack in the first FETCH cycle, exec_done in the first EXEC cycle).
- instruction_addr changes only on the exec_done edge or on reset.

Optional Feature:
- Macro: PC_SEQ_RET_STACK_EN.
- When defined:
  - Adds is_call, is_ret and stack_err, plus a 4-entry return-address stack.
  - Priority at exec_done: halt_req > is_ret > is_call > branch_taken > sequential.
  - is_call: push addr+1 (wrapped), then jump as for a taken branch. A push when full overwrites the oldest entry (circular); no error.
  - is_ret: pop into instruction_addr. A pop when empty gives addr+1 and sets stack_err (sticky until reset).
  - Reset empties the stack and clears stack_err.
- When undefined: these ports and the storage are absent; behaviour is exactly the base behaviour.

Test Plan:
- Reset then start, ack and exec_done each immediate, no branch, 17 instructions -> addr sequence 0,1,...,15,0; instr_valid pulses once per instruction; period 2 cycles.
- From addr=14: exec_done with branch_taken=1, offset=8'h03 -> addr=1. From addr=5: offset=8'hF0 (low bits 0) -> addr=6.
- imem_ack withheld 8 cycles (FETCH_TIMEOUT=8) -> state=ERR, timeout_err=1, imem_req=0. start is then ignored; only rst_n returns to IDLE with addr=0.
- At addr=7: exec_done with halt_req=1 and branch_taken=1 -> HALT, addr stays 7. start -> FETCH with imem_req=1 at addr 7.
- rst_n pulsed low mid-EXEC at addr=9 -> asynchronous return to IDLE, addr=0, instr_valid=0 without a clock edge. Stray exec_done in IDLE -> no change.
- (PC_SEQ_RET_STACK_EN) At addr=2: call with offset 4 -> addr 6; ret -> addr 3. A second ret on the empty stack -> addr 4, stack_err=1.
